// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: FSM state codes and
// the default 50 MHz timing constants.
package btn_pkg;

    typedef logic [2:0] btn_state_t;

    localparam btn_state_t ST_IDLE       = 3'd0;
    localparam btn_state_t ST_PRESS_WAIT = 3'd1;
    localparam btn_state_t ST_HELD       = 3'd2;
    localparam btn_state_t ST_REPEAT     = 3'd3;
    localparam btn_state_t ST_REL_WAIT   = 3'd4;

    localparam int unsigned DEBOUNCE_CYCLES_50M = 1_000_000;
    localparam int unsigned LONG_CYCLES_50M     = 50_000_000;
    localparam int unsigned REPEAT_CYCLES_50M   = 10_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input; both stages
// reset synchronously to RST_VAL.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronise, debounce, then derive press, release,
// long-press and auto-repeat strobes from the clean level.
//
// state      | meaning
// IDLE       | released, waiting for a pressed sample
// PRESS_WAIT | qualifying a press (dcnt counts stable pressed cycles)
// HELD       | press accepted, hcnt timing towards long press
// REPEAT     | long press flagged, rcnt timing auto-repeat
// REL_WAIT   | qualifying a release (dcnt counts stable released cycles)
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_50M,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_50M,
    parameter bit          ACTIVE_HIGH     = 1'b1
) (
    input  logic clk50_i,
    input  logic rstn_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o,
    output logic key_o
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HW = $clog2(LONG_CYCLES);
    localparam int unsigned RW = $clog2(REPEAT_CYCLES);

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

    logic btn_sync;
    logic s;

    sync_2ff #(
        .RST_VAL (logic'(!ACTIVE_HIGH))
    ) u_sync (
        .clk_i  (clk50_i),
        .rstn_i (rstn_i),
        .d_i    (btn_i),
        .q_o    (btn_sync)
    );

    assign s = ACTIVE_HIGH ? btn_sync : ~btn_sync;

    btn_state_t    state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          long_seen_q, long_seen_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          key_q, key_d;
    logic          timer_run;

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        hcnt_d      = hcnt_q;
        rcnt_d      = rcnt_q;
        long_seen_d = long_seen_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;
        timer_run   = (state_q == ST_HELD) || (state_q == ST_REPEAT) ||
                      (state_q == ST_REL_WAIT);

        // Hold timers keep running through a release bounce so that
        // long/repeat timing is measured from the press, not from the last bounce.
        if (timer_run) begin
            if (!long_seen_q) begin
                if (hcnt_q == H_LAST) begin
                    long_d      = 1'b1;
                    long_seen_d = 1'b1;
                    rcnt_d      = '0;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end else begin
                if (rcnt_q == R_LAST) begin
                    repeat_d = 1'b1;
                    rcnt_d   = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    dcnt_d  = '0;
                    state_d = ST_PRESS_WAIT;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_d = ST_IDLE;
                end else if (dcnt_q == D_LAST) begin
                    press_d     = 1'b1;
                    level_d     = 1'b1;
                    hcnt_d      = '0;
                    long_seen_d = 1'b0;
                    state_d     = ST_HELD;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            ST_HELD, ST_REPEAT: begin
                if (!s) begin
                    dcnt_d  = '0;
                    state_d = ST_REL_WAIT;
                end else if (long_seen_d) begin
                    state_d = ST_REPEAT;
                end
            end
            ST_REL_WAIT: begin
                if (s) begin
                    state_d = long_seen_d ? ST_REPEAT : ST_HELD;
                end else if (dcnt_q == D_LAST) begin
                    // An accepted release ends the press; it suppresses any timer strobe.
                    release_d = 1'b1;
                    long_d    = 1'b0;
                    repeat_d  = 1'b0;
                    level_d   = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        key_d = press_d | repeat_d;
    end

    always_ff @(posedge clk50_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            dcnt_q      <= '0;
            hcnt_q      <= '0;
            rcnt_q      <= '0;
            long_seen_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
            key_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            hcnt_q      <= hcnt_d;
            rcnt_q      <= rcnt_d;
            long_seen_q <= long_seen_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
            key_q       <= key_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign repeat_o  = repeat_q;
    assign key_o     = key_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: an active-high and an active-low instance driven with
// complementary pins, both checked every cycle against a run-length/timer model.
module tb_btn_debounce;

    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 6;
    localparam int LAT = 2 + D;

    logic clk = 1'b0;
    logic rstn;
    logic btn_h, btn_l;
    logic lvl_h, prs_h, rel_h, lng_h, rep_h, key_h;
    logic lvl_l, prs_l, rel_l, lng_l, rep_l, key_l;

    always #5 clk = ~clk;

    btn_debounce #(
        .DEBOUNCE_CYCLES (D), .LONG_CYCLES (L), .REPEAT_CYCLES (R), .ACTIVE_HIGH (1'b1)
    ) dut_h (
        .clk50_i (clk), .rstn_i (rstn), .btn_i (btn_h),
        .level_o (lvl_h), .press_o (prs_h), .release_o (rel_h),
        .long_o (lng_h), .repeat_o (rep_h), .key_o (key_h)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (D), .LONG_CYCLES (L), .REPEAT_CYCLES (R), .ACTIVE_HIGH (1'b0)
    ) dut_l (
        .clk50_i (clk), .rstn_i (rstn), .btn_i (btn_l),
        .level_o (lvl_l), .press_o (prs_l), .release_o (rel_l),
        .long_o (lng_l), .repeat_o (rep_l), .key_o (key_l)
    );

    int checks   = 0;
    int failures = 0;
    int ecnt     = 0;

    // reference model state: synchroniser pipe, accepted level, run length, time since press
    bit m_p1, m_p2, m_lvl;
    int m_run, m_t;
    bit e_press, e_rel, e_long, e_rep;

    int press_e, long_e, n_press, n_rel, n_long, n_rep;
    int rep_q[$];
    int k, base_press, base_rel, base_rep;
    bit cur;
    int len;

    task automatic chk(input string name, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d (edge %0d)", name, obs, exp, ecnt);
        end
    endtask

    task automatic model_edge(input bit b, input bit r);
        bit s;
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_rep = 1'b0;
        if (!r) begin
            m_p1 = 1'b0; m_p2 = 1'b0; m_lvl = 1'b0; m_run = 0; m_t = 0;
        end else begin
            s = m_p2;
            if (s != m_lvl) m_run++;
            else            m_run = 0;
            if (m_run == D + 1) begin
                m_run = 0;
                m_lvl = ~m_lvl;
                if (m_lvl) begin
                    e_press = 1'b1;
                    m_t = 0;
                end else begin
                    e_rel = 1'b1;
                end
            end else if (m_lvl) begin
                m_t++;
                if (m_t == L)                          e_long = 1'b1;
                else if (m_t > L && (m_t - L) % R == 0) e_rep  = 1'b1;
            end
            m_p2 = m_p1;
            m_p1 = b;
        end
    endtask

    task automatic step(input bit b, input bit r);
        btn_h = b;
        btn_l = ~b;
        rstn  = r;
        @(posedge clk);
        ecnt++;
        model_edge(b, r);
        @(negedge clk);
        chk("level_h",   lvl_h, m_lvl);
        chk("press_h",   prs_h, e_press);
        chk("release_h", rel_h, e_rel);
        chk("long_h",    lng_h, e_long);
        chk("repeat_h",  rep_h, e_rep);
        chk("key_h",     key_h, e_press | e_rep);
        chk("level_l",   lvl_l, m_lvl);
        chk("press_l",   prs_l, e_press);
        chk("release_l", rel_l, e_rel);
        chk("long_l",    lng_l, e_long);
        chk("repeat_l",  rep_l, e_rep);
        chk("key_l",     key_l, e_press | e_rep);
        if (prs_h) begin press_e = ecnt; n_press++; end
        if (rel_h) n_rel++;
        if (lng_h) begin long_e = ecnt; n_long++; end
        if (rep_h) begin rep_q.push_back(ecnt); n_rep++; end
    endtask

    task automatic hold(input bit b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b1);
    endtask

    initial begin
        rstn = 1'b0; btn_h = 1'b0; btn_l = 1'b1;
        press_e = -1; long_e = -1; n_press = 0; n_rel = 0; n_long = 0; n_rep = 0;
        @(negedge clk);

        // reset
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("rst_level", lvl_h, 0);
        chk("rst_key",   key_h, 0);
        hold(1'b0, 5);

        // clean press and release
        k = ecnt + 1; base_press = n_press;
        hold(1'b1, 10);
        chk("clean_press_lat", press_e - k, LAT);
        chk("clean_press_cnt", n_press - base_press, 1);
        k = ecnt + 1; base_rel = n_rel;
        hold(1'b0, 12);
        chk("clean_rel_cnt", n_rel - base_rel, 1);
        chk("clean_level_after", lvl_h, 0);

        // bounce shorter than the debounce window
        base_press = n_press;
        for (int i = 0; i < 5; i++) begin
            hold(1'b1, 2);
            hold(1'b0, 2);
        end
        hold(1'b0, 8);
        chk("bounce_press_cnt", n_press - base_press, 0);

        // long press with auto-repeat
        k = ecnt + 1; rep_q.delete();
        hold(1'b1, 50);
        chk("long_press_lat", press_e - k, LAT);
        chk("long_lat", long_e - press_e, L);
        chk("repeat_cnt", rep_q.size(), 3);
        if (rep_q.size() >= 2) begin
            chk("repeat1_lat", rep_q[0] - long_e, R);
            chk("repeat2_lat", rep_q[1] - long_e, 2 * R);
        end
        base_rel = n_rel;
        hold(1'b0, 12);
        chk("long_rel_cnt", n_rel - base_rel, 1);

        // release glitch while held
        k = ecnt + 1; base_rel = n_rel; base_rep = n_rep;
        hold(1'b1, 10);
        hold(1'b0, 2);
        hold(1'b1, 20);
        chk("glitch_rel_cnt", n_rel - base_rel, 0);
        chk("glitch_level", lvl_h, 1);
        chk("glitch_long_lat", long_e - press_e, L);
        hold(1'b0, 12);

        // reset mid-press
        hold(1'b1, 12);
        step(1'b1, 1'b0);
        chk("midrst_level", lvl_h, 0);
        chk("midrst_level_l", lvl_l, 0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        k = ecnt + 1; base_press = n_press;
        hold(1'b1, 12);
        chk("midrst_press_lat", press_e - k, LAT);
        chk("midrst_press_cnt", n_press - base_press, 1);
        hold(1'b0, 12);

        // randomised segments, with occasional resets
        cur = 1'b1;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0:       len = $urandom_range(1, D);
                1:       len = $urandom_range(D, 3 * D);
                2:       len = $urandom_range(L - 2, L + 3 * R);
                default: len = $urandom_range(1, 12);
            endcase
            if ($urandom_range(0, 24) == 0) step(cur, 1'b0);
            hold(cur, len);
            cur = ~cur;
        end
        hold(1'b0, 12);
        chk("final_level", lvl_h, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
